// File: rtl/timer_ctrl.sv
// Run/pause/clear controller for the seconds timer: button conditioning, tick prescaler,
// elapsed-seconds counter and DONE alarm. Define DEBOUNCE_EN to add a per-button stability filter.
module timer_ctrl #(
    parameter int unsigned CLK_SET     = 50_000_000,
    parameter int unsigned TIME_SET    = 99,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned ALARM_TICKS = 5,
    parameter int unsigned DB_CYCLES   = 1_000_000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             btn_start,
    input  logic             btn_clear,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             alarm
);

    localparam int unsigned PSC_W  = (CLK_SET > 2) ? $clog2(CLK_SET) : 1;
    localparam int unsigned ACNT_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

    localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(CLK_SET - 1);
    localparam logic [CNT_W-1:0]  CNT_TERM  = CNT_W'(TIME_SET);
    localparam logic [ACNT_W-1:0] ACNT_TERM = ACNT_W'(ALARM_TICKS);
    localparam logic              ALARM_ON  = (ALARM_TICKS != 0);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    // Configurations outside the supported range leave this marker block in the hierarchy
    if (CLK_SET < 2 || DB_CYCLES == 0) begin : g_unsupported_params
    end

    // Bit 0 is start, bit 1 is clear throughout the conditioning path
    logic [1:0] sync1, sync2, lvl, lvl_d;
    logic       start_p_c, clear_p_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_d <= '0;
        end else begin
            sync1 <= {btn_clear, btn_start};
            sync2 <= sync1;
            lvl_d <= lvl;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt [2];

    // Filtered level follows the synced level only after DB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl       <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        lvl[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign lvl = sync2;
`endif

    assign start_p_c = lvl[0] & ~lvl_d[0];
    assign clear_p_c = lvl[1] & ~lvl_d[1];

    state_t              state, state_nxt;
    logic [PSC_W-1:0]    psc, psc_nxt;
    logic [ACNT_W-1:0]   acnt, acnt_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                alarm_nxt, tick_nxt, wrap_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            count   <= '0;
            psc     <= '0;
            acnt    <= '0;
            alarm   <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            psc     <= psc_nxt;
            acnt    <= acnt_nxt;
            alarm   <= alarm_nxt;
            tick    <= tick_nxt;
            running <= (state_nxt == RUN);
            paused  <= (state_nxt == PAUSE);
            done    <= (state_nxt == DONE);
        end
    end

    // Next state; clear overrides every other event in the same cycle
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        psc_nxt   = psc;
        acnt_nxt  = acnt;
        alarm_nxt = alarm;
        wrap_c    = ((state == RUN) || (state == DONE)) && (psc == PSC_LAST);

        case (state)
            IDLE: begin
                psc_nxt = '0;
                if (start_p_c) begin
                    count_nxt = '0;
                    if (TIME_SET == 0) begin
                        state_nxt = DONE;
                        alarm_nxt = ALARM_ON;
                        acnt_nxt  = '0;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                psc_nxt = wrap_c ? '0 : psc + PSC_W'(1);
                if (wrap_c) begin
                    if (count != CNT_TERM) begin
                        count_nxt = count + CNT_W'(1);
                    end
                    if (count == CNT_TERM || count + CNT_W'(1) == CNT_TERM) begin
                        state_nxt = DONE;
                        alarm_nxt = ALARM_ON;
                        acnt_nxt  = '0;
                    end
                end
                // A pause coinciding with the final tick loses to DONE so count cannot exceed TIME_SET
                if (start_p_c && state_nxt == RUN) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (start_p_c) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                psc_nxt = wrap_c ? '0 : psc + PSC_W'(1);
                if (wrap_c && alarm) begin
                    acnt_nxt = acnt + ACNT_W'(1);
                    if (acnt + ACNT_W'(1) == ACNT_TERM) begin
                        alarm_nxt = 1'b0;
                    end
                end
                if (start_p_c) begin
                    state_nxt = RUN;
                    count_nxt = '0;
                    psc_nxt   = '0;
                    acnt_nxt  = '0;
                    alarm_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (clear_p_c) begin
            state_nxt = IDLE;
            count_nxt = '0;
            psc_nxt   = '0;
            acnt_nxt  = '0;
            alarm_nxt = 1'b0;
        end

        // Registered tick lines up with the cycle in which psc sits at its last value
        tick_nxt = ((state_nxt == RUN) || (state_nxt == DONE)) && (psc_nxt == PSC_LAST);
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with CLK_SET=4, TIME_SET=5, ALARM_TICKS=2, DB_CYCLES=3.
// Define DEBOUNCE_EN for both files to exercise the filtered build.
module tb_timer_ctrl;

    localparam int unsigned CNT_W = 8;
`ifdef DEBOUNCE_EN
    localparam int LAT  = 6;
    localparam int HOLD = 4;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             btn_start = 1'b0;
    logic             btn_clear = 1'b0;
    logic [CNT_W-1:0] count;
    logic             tick, running, paused, done, alarm;

    int checks   = 0;
    int failures = 0;
    int saw_tick;

    timer_ctrl #(
        .CLK_SET    (4),
        .TIME_SET   (5),
        .CNT_W      (CNT_W),
        .ALARM_TICKS(2),
        .DB_CYCLES  (3)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .count    (count),
        .tick     (tick),
        .running  (running),
        .paused   (paused),
        .done     (done),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge on which the press changes state
    task automatic press(input logic s, input logic c);
        btn_start = s;
        btn_clear = c;
        step(HOLD);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step(LAT - HOLD);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        step(2);
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_paused", paused, 0);
        check("rst_done", done, 0);
        check("rst_alarm", alarm, 0);
        check("rst_tick", tick, 0);
        @(negedge clk) rstn = 1'b1;
        step(1);

`ifdef DEBOUNCE_EN
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(10);
        check("glitch_ignored", running, 0);
        btn_start = 1'b1;
        step(4);
        btn_start = 1'b0;
        step(1);
        check("db_edge5_idle", running, 0);
        step(1);
        check("db_edge6_run", running, 1);
        press(0, 1);
        check("db_cleared", running, 0);
`endif

        // Full run to DONE and alarm expiry
        press(1, 0);
        check("run_running", running, 1);
        check("run_count0", count, 0);
        step(3);
        check("run_tick1", tick, 1);
        check("run_tick1_count", count, 0);
        step(1);
        check("run_tick_low", tick, 0);
        check("run_count1", count, 1);
        step(15);
        check("run_count4", count, 4);
        check("run_not_done", done, 0);
        step(1);
        check("done_count", count, 5);
        check("done_flag", done, 1);
        check("done_running", running, 0);
        check("done_alarm", alarm, 1);
        step(7);
        check("alarm_held", alarm, 1);
        step(1);
        check("alarm_dropped", alarm, 0);
        check("done_count_hold", count, 5);
        check("done_still", done, 1);

        // Restart from DONE
        press(1, 0);
        check("restart_count", count, 0);
        check("restart_running", running, 1);
        check("restart_alarm", alarm, 0);
        check("restart_done", done, 0);
        step(19);
        check("restart_before_done", done, 0);
        step(1);
        check("restart_done_again", done, 1);
        check("restart_count5", count, 5);

        press(0, 1);
        check("clr_running", running, 0);
        check("clr_done", done, 0);
        check("clr_count", count, 0);
        check("clr_alarm", alarm, 0);

        // Pause at count=2 with psc=1, hold, then resume
        press(1, 0);
        step(9 - LAT);
        press(1, 0);
        check("pause_flag", paused, 1);
        check("pause_running", running, 0);
        check("pause_count", count, 2);
        saw_tick = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick) saw_tick++;
        end
        check("pause_no_tick", saw_tick, 0);
        check("pause_count_frozen", count, 2);
        press(1, 0);
        check("resume_running", running, 1);
        check("resume_paused", paused, 0);
        check("resume_tick0", tick, 0);
        step(1);
        check("resume_1_tick", tick, 0);
        step(1);
        check("resume_2_tick", tick, 1);
        check("resume_2_count", count, 2);
        step(1);
        check("resume_count3", count, 3);

        // Start and clear together: clear wins
        press(1, 1);
        check("both_running", running, 0);
        check("both_paused", paused, 0);
        check("both_count", count, 0);

        // Clear coincident with the tick that would reach count=5
        press(1, 0);
        step(20 - LAT);
        btn_clear = 1'b1;
        step(HOLD);
        btn_clear = 1'b0;
        step(LAT - HOLD - 1);
        check("clrtick_tick", tick, 1);
        check("clrtick_count4", count, 4);
        step(1);
        check("clrtick_count", count, 0);
        check("clrtick_done", done, 0);
        check("clrtick_running", running, 0);
        check("clrtick_tick_low", tick, 0);

        // Asynchronous reset mid-RUN
        press(1, 0);
        step(5);
        check("pre_rst_count", count, 1);
        rstn = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_running", running, 0);
        check("async_tick", tick, 0);
        check("async_alarm", alarm, 0);
        @(negedge clk) rstn = 1'b1;
        step(2);
        check("post_rst_running", running, 0);
        check("post_rst_count", count, 0);
        press(1, 0);
        check("post_rst_start", running, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
